imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder: the memory side of the fetch interface that the IF
//   stage drives. Takes the fetch address from IF and returns the addressed
//   instruction word from an internal word array.
//   A load port lets the testbench or boot logic program the array.
//   Flags out-of-range and misaligned fetches.
//   Clears the whole array to NOP after reset.
// PARAMETERS
//   DEPTH      256           number of 32-bit instruction words (power of 2, >=4)
//   BASE_ADDR  32'h0000_0000 byte address of word 0 (DEPTH*4-aligned)
//   NOP_INSTR  32'h0000_0013 word returned when no valid instruction (addi x0,x0,0)
// PORTS
//   i_clk            in   1   clock, all state on rising edge
//   i_reset_n        in   1   asynchronous active-low reset
//   i_mem_instrAddr  in   32  fetch byte address from IF
//   o_mem_instr      out  32  fetched instruction, registered
//   o_instr_valid    out  1   o_mem_instr holds a real array word
//   o_fault          out  1   previous fetch was misaligned or out of range
//   i_ld_start       in   1   request entry to LOAD state (1-cycle pulse)
//   i_ld_wr          in   1   write i_ld_data at i_ld_addr (honoured in LOAD only)
//   i_ld_addr        in   32  load byte address
//   i_ld_data        in   32  load word
//   i_ld_done        in   1   leave LOAD state (1-cycle pulse)
//   o_ld_err         out 1    last load write was dropped (bad address / not LOAD)
//   o_busy           out  1   state != RUN
// BEHAVIOUR
//   Reset (async, i_reset_n=0):
//     - state=CLEAR, clr_cnt=0.
//     - o_mem_instr=NOP_INSTR; o_instr_valid, o_fault and o_ld_err = 0; o_busy=1.
//     - Array contents are not reset, only overwritten by CLEAR.
//   FSM:
//     - CLEAR: writes NOP_INSTR to word clr_cnt each cycle; clr_cnt++.
//       At clr_cnt==DEPTH-1 the write happens and next state is RUN (DEPTH cycles total).
//       i_ld_* ignored.
//     - RUN: i_ld_start=1 -> LOAD. i_ld_done alone is ignored.
//       i_ld_start and i_ld_done together -> LOAD (start wins).
//     - LOAD: i_ld_wr writes the word when its address is valid. i_ld_done=1 -> RUN.
//       i_ld_wr on the i_ld_done cycle is still honoured. i_ld_start is ignored.
//   Address check (fetch and load): ok = addr[1:0]==0 && BASE_ADDR <= addr < BASE_ADDR+4*DEPTH.
//     Word index = (addr-BASE_ADDR)[$clog2(DEPTH)+1:2].
//     The address is compared at full 32 bits: no wrap-around, no truncation aliasing.
//   Fetch (every cycle, latency 1, no handshake):
//     - State RUN and ok: o_mem_instr<=mem[idx]; o_instr_valid<=1; o_fault<=0.
//     - State RUN and !ok: o_mem_instr<=NOP_INSTR; o_instr_valid<=0; o_fault<=1.
//     - State != RUN: o_mem_instr<=NOP_INSTR; o_instr_valid<=0; o_fault<=0.
//     - The fetch is evaluated using the state before the edge. The first cycle after
//       the LOAD->RUN edge still returns NOP.
//   Load write: a word written in cycle N is visible to a fetch issued in any cycle >= N+1.
//   o_ld_err (registered, level):
//     - Set to 1 on i_ld_wr when state != LOAD or the address is not ok.
//     - Cleared to 0 on any accepted i_ld_wr.
//     - Otherwise held.
//   o_busy is combinational from the state register.
//   Reset mid-CLEAR or mid-LOAD: returns to CLEAR at clr_cnt=0 and clears again.
// STRUCTURE
//   Package imem_pkg:
//     - typedef enum logic [1:0] {CLEAR, RUN, LOAD} imem_state_t
//     - localparam NOP_INSTR default
//     - function addr_ok(addr, base, depth)
//   Sub-module imem_ram: DEPTH x 32 array, one synchronous write port, one synchronous
//   read port. The read port has no reset; the valid/NOP muxing stays in the top.
//   Top holds the FSM, clr_cnt, address checks and the output registers.
// TESTING
//   1 Reset, DEPTH=16:
//     -> o_busy=1 for exactly 16 cycles after release.
//     -> Then every fetch of 0x00..0x3C returns 0x00000013 with o_instr_valid=1.
//   2 ld_start; ld_wr 0x04<=0xDEADBEEF and 0x3C<=0x00A00093; ld_done:
//     -> In RUN, a fetch of 0x04 gives 0xDEADBEEF with valid=1 on the next edge.
//     -> A fetch of 0x3C gives 0x00A00093.
//   3 Fetches in RUN:
//     -> 0x06 (misaligned): NOP, valid=0, fault=1.
//     -> 0x40 (range, DEPTH=16): NOP, valid=0, fault=1.
//     -> 0xFFFFFFFC: NOP, valid=0, fault=1.
//     -> Next fetch 0x00: fault=0.
//   4 ld_wr in RUN to 0x08:
//     -> o_ld_err=1 and the array is unchanged.
//     -> ld_wr in LOAD to 0x41: o_ld_err stays 1.
//     -> A valid LOAD write: o_ld_err=0.
//   5 ld_start and ld_done together in RUN:
//     -> LOAD entered.
//     -> ld_wr and ld_done together: the write lands and the state is RUN.
//   6 Assert i_reset_n=0 for 1 cycle in the middle of LOAD after writing 0x04:
//     -> Outputs go to reset values immediately.
//     -> A full CLEAR follows.
//     -> A fetch of 0x04 then returns 0x00000013.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types, constants and address-range helper for the instruction memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Word-aligned and inside [base, base+span); 33-bit math so the top of the
  // address space neither wraps nor aliases onto low words.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [32:0] span);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = lo + span;
    a  = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 word array, one synchronous write port and one unreset synchronous read port.
module imem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write and read on the same edge; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: answers IF fetches from an internal array,
// clears it to NOP after reset and accepts programming in a LOAD phase.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_mem_instrAddr,
  output logic [31:0] o_mem_instr,
  output logic        o_instr_valid,
  output logic        o_fault,
  input  logic        i_ld_start,
  input  logic        i_ld_wr,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_done,
  output logic        o_ld_err,
  output logic        o_busy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  imem_state_t   state;
  imem_state_t   state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   fetch_off;
  logic [31:0]   ld_off;
  logic          fetch_ok;
  logic          ld_ok;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          ld_accept;

  // Address decode for the fetch and load ports.
  always_comb begin
    fetch_off = i_mem_instrAddr - BASE_ADDR;
    ld_off    = i_ld_addr - BASE_ADDR;
    fetch_ok  = addr_ok(i_mem_instrAddr, BASE_ADDR, SPAN);
    ld_ok     = addr_ok(i_ld_addr, BASE_ADDR, SPAN);
  end

  // Next-state logic and array write-port steering.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = clr_cnt;
    ram_wdata = NOP_INSTR;
    ld_accept = 1'b0;
    unique case (state)
      CLEAR: begin
        ram_we = 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_ld_start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_accept = i_ld_wr && ld_ok;
        ram_we    = ld_accept;
        ram_waddr = AW'(ld_off >> 2);
        ram_wdata = i_ld_data;
        if (i_ld_done) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // State register and clear counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end else begin
        clr_cnt <= '0;
      end
    end
  end

  // Fetch status and load-error flags, evaluated with the pre-edge state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instr_valid <= 1'b0;
      o_fault       <= 1'b0;
      o_ld_err      <= 1'b0;
    end else begin
      o_instr_valid <= (state == RUN) && fetch_ok;
      o_fault       <= (state == RUN) && !fetch_ok;
      if (i_ld_wr && (state != CLEAR)) begin
        o_ld_err <= !ld_accept;
      end
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (AW'(fetch_off >> 2)),
    .rdata (ram_rdata)
  );

  // The read register is unreset, so the registered valid flag selects NOP otherwise.
  assign o_mem_instr = o_instr_valid ? ram_rdata : NOP_INSTR;
  assign o_busy      = (state != RUN);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with DEPTH=16.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_mem_instrAddr;
  logic [31:0] o_mem_instr;
  logic        o_instr_valid;
  logic        o_fault;
  logic        i_ld_start;
  logic        i_ld_wr;
  logic [31:0] i_ld_addr;
  logic [31:0] i_ld_data;
  logic        i_ld_done;
  logic        o_ld_err;
  logic        o_busy;

  int n_assert = 0;
  int n_fail   = 0;

  imem_responder #(
    .DEPTH     (16),
    .BASE_ADDR (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_mem_instrAddr (i_mem_instrAddr),
    .o_mem_instr     (o_mem_instr),
    .o_instr_valid   (o_instr_valid),
    .o_fault         (o_fault),
    .i_ld_start      (i_ld_start),
    .i_ld_wr         (i_ld_wr),
    .i_ld_addr       (i_ld_addr),
    .i_ld_data       (i_ld_data),
    .i_ld_done       (i_ld_done),
    .o_ld_err        (o_ld_err),
    .o_busy          (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] instr,
                             input logic valid, input logic fault);
    check({tag, " instr"}, o_mem_instr, instr);
    check({tag, " valid"}, 32'(o_instr_valid), 32'(valid));
    check({tag, " fault"}, 32'(o_fault), 32'(fault));
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd16);
  endtask

  initial begin
    i_reset_n       = 1'b0;
    i_mem_instrAddr = 32'h0;
    i_ld_start      = 1'b0;
    i_ld_wr         = 1'b0;
    i_ld_addr       = 32'h0;
    i_ld_data       = 32'h0;
    i_ld_done       = 1'b0;

    // 1: reset values, CLEAR length, all words NOP
    tick();
    tick();
    check_fetch("rst", NOP, 1'b0, 1'b0);
    check("rst busy", 32'(o_busy), 32'd1);
    check("rst ld_err", 32'(o_ld_err), 32'd0);
    i_reset_n = 1'b1;
    count_clear("clear cycles");
    for (int a = 0; a <= 32'h3C; a += 4) begin
      i_mem_instrAddr = 32'(a);
      tick();
      check_fetch($sformatf("cleared %0h", a), NOP, 1'b1, 1'b0);
    end

    // 2: program two words, then fetch them
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    check("load entered", 32'(o_busy), 32'd1);
    i_ld_wr = 1'b1; i_ld_addr = 32'h04; i_ld_data = 32'hDEAD_BEEF;
    tick();
    i_ld_addr = 32'h3C; i_ld_data = 32'h00A0_0093;
    tick();
    i_ld_wr = 1'b0; i_ld_done = 1'b1;
    i_mem_instrAddr = 32'h04;
    tick();
    i_ld_done = 1'b0;
    check("load exit", 32'(o_busy), 32'd0);
    check_fetch("load->run edge", NOP, 1'b0, 1'b0);
    tick();
    check_fetch("fetch 04", 32'hDEAD_BEEF, 1'b1, 1'b0);
    i_mem_instrAddr = 32'h3C;
    tick();
    check_fetch("fetch 3c", 32'h00A0_0093, 1'b1, 1'b0);

    // 3: faults
    i_mem_instrAddr = 32'h06;
    tick();
    check_fetch("misaligned", NOP, 1'b0, 1'b1);
    i_mem_instrAddr = 32'h40;
    tick();
    check_fetch("range 40", NOP, 1'b0, 1'b1);
    i_mem_instrAddr = 32'hFFFF_FFFC;
    tick();
    check_fetch("range top", NOP, 1'b0, 1'b1);
    i_mem_instrAddr = 32'h00;
    tick();
    check_fetch("after fault", NOP, 1'b1, 1'b0);

    // 4: load error behaviour
    i_ld_wr = 1'b1; i_ld_addr = 32'h08; i_ld_data = 32'h1234_5678;
    tick();
    i_ld_wr = 1'b0;
    check("ld_err run", 32'(o_ld_err), 32'd1);
    i_mem_instrAddr = 32'h08;
    tick();
    check_fetch("run write dropped", NOP, 1'b1, 1'b0);
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    i_ld_wr = 1'b1; i_ld_addr = 32'h41; i_ld_data = 32'h5555_AAAA;
    tick();
    check("ld_err bad addr", 32'(o_ld_err), 32'd1);
    i_ld_addr = 32'h10; i_ld_data = 32'hCAFE_F00D;
    tick();
    check("ld_err cleared", 32'(o_ld_err), 32'd0);
    i_ld_wr = 1'b0; i_ld_done = 1'b1;
    tick();
    i_ld_done = 1'b0;
    i_mem_instrAddr = 32'h10;
    tick();
    check_fetch("fetch 10", 32'hCAFE_F00D, 1'b1, 1'b0);

    // 5: start+done together, then write+done together
    i_ld_start = 1'b1; i_ld_done = 1'b1;
    tick();
    i_ld_start = 1'b0; i_ld_done = 1'b0;
    check("start wins", 32'(o_busy), 32'd1);
    i_ld_wr = 1'b1; i_ld_done = 1'b1; i_ld_addr = 32'h14; i_ld_data = 32'h1111_2222;
    i_mem_instrAddr = 32'h14;
    tick();
    i_ld_wr = 1'b0; i_ld_done = 1'b0;
    check("wr+done exit", 32'(o_busy), 32'd0);
    tick();
    check_fetch("fetch 14", 32'h1111_2222, 1'b1, 1'b0);

    // 6: reset in the middle of LOAD
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    i_ld_wr = 1'b1; i_ld_addr = 32'h04; i_ld_data = 32'hABCD_0001;
    tick();
    i_ld_addr = 32'h41;
    tick();
    i_ld_wr = 1'b0;
    check("pre-reset ld_err", 32'(o_ld_err), 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_fetch("async rst", NOP, 1'b0, 1'b0);
    check("async rst busy", 32'(o_busy), 32'd1);
    check("async rst ld_err", 32'(o_ld_err), 32'd0);
    tick();
    i_reset_n = 1'b1;
    i_mem_instrAddr = 32'h04;
    count_clear("reclear cycles");
    tick();
    check_fetch("fetch 04 after reclear", NOP, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
